// File: rtl/ram_dual_param.sv
// -----------------------------------------------------------------------------
// ram_dual_param
//
// Parametrised single-clock simple-dual-port RAM used for the VGA frame and
// line buffers. One write port (pixel producer), one read port (scan-out).
// After every reset a clear sequencer writes CLR_VAL to all DEPTH words, one
// word per cycle, so the scan-out never sees undefined contents. While the
// clear runs, init_busy is high and both ports are ignored.
//
// Optional build macro:
//   RAM_DUAL_BYPASS_EN  defined   -> write-first: q reflects every write that
//                                    has landed up to and including the edge
//                                    on which q is updated.
//                       undefined -> read-first: q returns the word as it was
//                                    before the request edge; no forwarding
//                                    logic exists.
//
// Parameters:
//   DATA_W   word width in bits (multiple of 8)
//   ADDR_W   address width in bits
//   DEPTH    number of words (DEPTH <= 2**ADDR_W)
//   RD_LAT   read latency, 1 or 2 cycles
//   CLR_VAL  value written to every word by the clear sequence
//
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   we         write strobe
//   be         byte enables, bit i selects d[8i+7:8i]
//   addr_in    write address
//   d          write data
//   re         read request
//   addr_out   read address
//   q          read data (holds its value between reads)
//   q_valid    one-cycle strobe per accepted read request
//   init_busy  clear sequence in progress
//   wr_err     one-cycle pulse after a dropped write
// -----------------------------------------------------------------------------
module ram_dual_param #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       ADDR_W  = 13,
  parameter int unsigned       DEPTH   = 5626,
  parameter int unsigned       RD_LAT  = 2,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr_in,
  input  logic [DATA_W-1:0]   d,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr_out,
  output logic [DATA_W-1:0]   q,
  output logic                q_valid,
  output logic                init_busy,
  output logic                wr_err
);

  localparam int               NB      = DATA_W / 8;
  // Only the low IDX_W address bits are needed to index the array once an
  // address has been range-checked.
  localparam int unsigned      IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

`ifdef RAM_DUAL_BYPASS_EN
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [NB-1:0]     lane_en,
                                                    input logic [DATA_W-1:0] new_w);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < NB; i++) begin
      if (lane_en[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction
`endif

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d;
  logic               busy;
  logic               wr_ok;
  logic               rd_req;
  logic               wr_err_q;
  logic [DATA_W-1:0]  dout_q;
  logic               valid_q;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic               mem_we;
  logic [IDX_W-1:0]   mem_idx;
  logic [NB-1:0]      mem_be;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  rd_word;

  assign busy   = (state_q == ST_CLEAR);
  assign wr_ok  = !busy && we && in_range(addr_in);
  assign rd_req = re && !busy;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_L) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: ;
      default: state_d = ST_CLEAR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write port: the clear sequencer owns the array while busy.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = addr_in[IDX_W-1:0];
    mem_be    = be;
    mem_wdata = d;
    if (rst_n) begin
      if (busy) begin
        mem_we    = 1'b1;
        mem_idx   = cnt_q[IDX_W-1:0];
        mem_be    = '1;
        mem_wdata = CLR_VAL;
      end else if (wr_ok) begin
        mem_we = 1'b1;
      end
    end
  end

  // NOTE: the array has no reset; resetting it would prevent RAM inference.
  // Defined contents come from the clear sequence instead.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wr_err_q <= 1'b0;
    else        wr_err_q <= we && (busy || !in_range(addr_in));
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  // Word seen at the request edge; out-of-range reads return zero.
  always_comb begin
    rd_word = '0;
    if (in_range(addr_out)) begin
      rd_word = mem_q[addr_out[IDX_W-1:0]];
`ifdef RAM_DUAL_BYPASS_EN
      if (wr_ok && (addr_in == addr_out)) rd_word = merge_bytes(rd_word, be, d);
`endif
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        dout_q  <= '0;
      end else begin
        valid_q <= rd_req;
        if (rd_req) dout_q <= rd_word;
      end
    end
  end else begin : g_lat2
    // The array is sampled at the request edge so that read-first semantics
    // hold relative to that edge; the second stage only retimes the word.
    logic              req1_q;
    logic [DATA_W-1:0] data1_q;
    logic [DATA_W-1:0] data2_d;
`ifdef RAM_DUAL_BYPASS_EN
    logic [ADDR_W-1:0] addr1_q;
`endif

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        req1_q  <= 1'b0;
        data1_q <= '0;
`ifdef RAM_DUAL_BYPASS_EN
        addr1_q <= '0;
`endif
      end else begin
        req1_q <= rd_req;
        if (rd_req) begin
          data1_q <= rd_word;
`ifdef RAM_DUAL_BYPASS_EN
          addr1_q <= addr_out;
`endif
        end
      end
    end

    // A write landing on the data edge to the in-flight address is merged
    // in, so q matches the array contents after that edge.
    always_comb begin
      data2_d = data1_q;
`ifdef RAM_DUAL_BYPASS_EN
      if (wr_ok && (addr_in == addr1_q)) data2_d = merge_bytes(data1_q, be, d);
`endif
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        dout_q  <= '0;
      end else begin
        valid_q <= req1_q;
        if (req1_q) dout_q <= data2_d;
      end
    end
  end

  assign q         = dout_q;
  assign q_valid   = valid_q;
  assign init_busy = busy;
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_ram_dual_param.sv
// -----------------------------------------------------------------------------
// tb_ram_dual_param
//
// Drives one RD_LAT=1 and one RD_LAT=2 instance (DEPTH=16, CLR_VAL=DEADBEEF)
// with identical stimulus. A memory-level reference model predicts every
// output after every clock edge; directed tables and short hand sequences add
// fixed expectations for the clear, byte-enable, pipelining, range and
// collision cases.
// -----------------------------------------------------------------------------
module tb_ram_dual_param;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 5;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] CLR    = 32'hDEADBEEF;
  localparam logic [31:0] DB     = 32'hDEADBEEF;
  localparam logic [31:0] X5     = 32'h11BB33DD;
`ifdef RAM_DUAL_BYPASS_EN
  localparam logic [31:0] COLL   = 32'h2;
  localparam bit          BYPASS = 1'b1;
`else
  localparam logic [31:0] COLL   = 32'h1;
  localparam bit          BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  be;
  logic [4:0]  addr_in;
  logic [31:0] d;
  logic        re;
  logic [4:0]  addr_out;

  logic [31:0] q1, q2;
  logic        v1, v2, busy1, busy2, err1, err2;

  ram_dual_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(1), .CLR_VAL(CLR))
  u_lat1 (.clk(clk), .rst_n(rst_n), .we(we), .be(be), .addr_in(addr_in), .d(d),
          .re(re), .addr_out(addr_out), .q(q1), .q_valid(v1), .init_busy(busy1),
          .wr_err(err1));

  ram_dual_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(2), .CLR_VAL(CLR))
  u_lat2 (.clk(clk), .rst_n(rst_n), .we(we), .be(be), .addr_in(addr_in), .d(d),
          .re(re), .addr_out(addr_out), .q(q2), .q_valid(v2), .init_busy(busy2),
          .wr_err(err2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a plain word array plus the rules for clear, writes and
  // the two read latencies.
  // ---------------------------------------------------------------------------
  logic [31:0] m_mem [DEPTH];
  bit          m_busy, m_err, m_v1, m_v2;
  int          m_cnt;
  logic [31:0] m_q1, m_q2;
  bit          p_v;
  logic [4:0]  p_addr;
  logic [31:0] p_word;

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    return (int'(a) < DEPTH) ? m_mem[a[3:0]] : 32'h0;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [3:0] en,
                                          input logic [31:0] n);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (en[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic model_step();
    bit          req;
    logic [31:0] old_w, resp;
    if (!rst_n) begin
      m_busy = 1'b1; m_cnt = 0; m_err = 1'b0;
      m_v1 = 1'b0; m_v2 = 1'b0; m_q1 = '0; m_q2 = '0; p_v = 1'b0;
    end else begin
      req   = re && !m_busy;
      old_w = m_rd(addr_out);
      if (m_busy) begin
        m_mem[m_cnt[3:0]] = CLR;
        m_cnt++;
        if (m_cnt == DEPTH) m_busy = 1'b0;
        m_err = we;
      end else begin
        m_err = we && (int'(addr_in) >= DEPTH);
        if (we && int'(addr_in) < DEPTH) m_mem[addr_in[3:0]] = m_merge(m_mem[addr_in[3:0]], be, d);
      end
      resp = BYPASS ? m_rd(addr_out) : old_w;
      m_v1 = req;
      if (req) m_q1 = resp;
      m_v2 = p_v;
      if (p_v) m_q2 = BYPASS ? m_rd(p_addr) : p_word;
      p_v = req; p_addr = addr_out; p_word = old_w;
    end
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("busy_l1", 32'(busy1), 32'(m_busy));
    check("busy_l2", 32'(busy2), 32'(m_busy));
    check("err_l1",  32'(err1),  32'(m_err));
    check("err_l2",  32'(err2),  32'(m_err));
    check("vld_l1",  32'(v1),    32'(m_v1));
    check("vld_l2",  32'(v2),    32'(m_v2));
    check("q_l1",    q1,         m_q1);
    check("q_l2",    q2,         m_q2);
  endtask

  task automatic idle();
    we = 1'b0; be = 4'h0; addr_in = 5'd0; d = 32'h0; re = 1'b0; addr_out = 5'd0;
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [4:0]  wa;
    logic [31:0] d;
    logic        re;
    logic [4:0]  ra;
    logic        e_err;
    logic        e_v1;
    logic [31:0] e_q1;
    logic        e_v2;
    logic [31:0] e_q2;
  } vec_t;

  vec_t tbl [23];

  initial begin
    int  busy_cycles;
    bit  saw_valid;

    tbl[0]  = '{1'b1, 4'hF, 5'd5,  32'h11223344, 1'b0, 5'd0,  1'b0, 1'b0, DB,     1'b0, DB};
    tbl[1]  = '{1'b1, 4'h5, 5'd5,  32'hAABBCCDD, 1'b0, 5'd0,  1'b0, 1'b0, DB,     1'b0, DB};
    tbl[2]  = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 1'b1, X5,     1'b0, DB};
    tbl[3]  = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b0, X5,     1'b1, X5};
    tbl[4]  = '{1'b1, 4'hF, 5'd0,  32'd10,       1'b0, 5'd0,  1'b0, 1'b0, X5,     1'b0, X5};
    tbl[5]  = '{1'b1, 4'hF, 5'd1,  32'd20,       1'b0, 5'd0,  1'b0, 1'b0, X5,     1'b0, X5};
    tbl[6]  = '{1'b1, 4'hF, 5'd2,  32'd30,       1'b0, 5'd0,  1'b0, 1'b0, X5,     1'b0, X5};
    tbl[7]  = '{1'b1, 4'hF, 5'd3,  32'd40,       1'b0, 5'd0,  1'b0, 1'b0, X5,     1'b0, X5};
    tbl[8]  = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 1'b1, 32'd10, 1'b0, X5};
    tbl[9]  = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b1, 5'd1,  1'b0, 1'b1, 32'd20, 1'b1, 32'd10};
    tbl[10] = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b1, 5'd2,  1'b0, 1'b1, 32'd30, 1'b1, 32'd20};
    tbl[11] = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 1'b1, 32'd40, 1'b1, 32'd30};
    tbl[12] = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 32'd40, 1'b1, 32'd40};
    tbl[13] = '{1'b1, 4'hF, 5'd16, 32'hFFFFFFFF, 1'b0, 5'd0,  1'b1, 1'b0, 32'd40, 1'b0, 32'd40};
    tbl[14] = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b1, 5'd16, 1'b0, 1'b1, 32'h0,  1'b0, 32'd40};
    tbl[15] = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 32'h0,  1'b1, 32'h0};
    tbl[16] = '{1'b1, 4'h0, 5'd6,  32'h55555555, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    tbl[17] = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b1, 5'd6,  1'b0, 1'b1, DB,     1'b0, 32'h0};
    tbl[18] = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 1'b1, 32'd10, 1'b1, DB};
    tbl[19] = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b0, 32'd10, 1'b1, 32'd10};
    tbl[20] = '{1'b1, 4'hF, 5'd7,  32'h1,        1'b0, 5'd0,  1'b0, 1'b0, 32'd10, 1'b0, 32'd10};
    tbl[21] = '{1'b1, 4'hF, 5'd7,  32'h2,        1'b1, 5'd7,  1'b0, 1'b1, COLL,   1'b0, 32'd10};
    tbl[22] = '{1'b0, 4'h0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 1'b0, COLL,   1'b1, COLL};

    // Reset state.
    rst_n = 1'b0;
    idle();
    tick();
    check("rst_busy", 32'(busy1 & busy2), 32'h1);
    check("rst_q",    q1 | q2,            32'h0);
    check("rst_vld",  32'(v1 | v2),       32'h0);
    check("rst_err",  32'(err1 | err2),   32'h0);
    tick();

    // Reset in the middle of the clear: reads requested throughout.
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      re = 1'b1; addr_out = 5'(i);
      tick();
      if (v1 || v2) saw_valid = 1'b1;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Full clear after release, with a write attempt at address 9.
    busy_cycles = 0;
    while (busy1 && busy_cycles < 100) begin
      we = (busy_cycles == 3); be = 4'hF; addr_in = 5'd9; d = 32'h12345678;
      re = 1'b1; addr_out = 5'(busy_cycles % 16);
      tick();
      busy_cycles++;
      if (v1 || v2) saw_valid = 1'b1;
      if (busy_cycles == 4) check("clr_wr_err", 32'(err1 & err2), 32'h1);
      if (busy_cycles == 5) check("clr_wr_err_end", 32'(err1 | err2), 32'h0);
    end
    check("clr_busy_cycles", 32'(busy_cycles), 32'd16);
    check("clr_no_valid", 32'(saw_valid), 32'h0);
    idle();

    // Every word reads CLR_VAL (address 9 included).
    for (int i = 0; i < DEPTH; i++) begin
      re = 1'b1; addr_out = 5'(i);
      tick();
      check("clr_rd_vld", 32'(v1), 32'h1);
      check("clr_rd_q", q1, DB);
      if (i > 0) check("clr_rd_q_l2", q2, DB);
    end
    idle();
    tick();
    check("clr_rd_q_l2_last", q2, DB);

    // Directed table.
    for (int i = 0; i < 23; i++) begin
      we = tbl[i].we; be = tbl[i].be; addr_in = tbl[i].wa; d = tbl[i].d;
      re = tbl[i].re; addr_out = tbl[i].ra;
      tick();
      check($sformatf("tbl%0d_err", i),    32'(err1 & err2), 32'(tbl[i].e_err));
      check($sformatf("tbl%0d_vld_l1", i), 32'(v1),          32'(tbl[i].e_v1));
      check($sformatf("tbl%0d_q_l1", i),   q1,               tbl[i].e_q1);
      check($sformatf("tbl%0d_vld_l2", i), 32'(v2),          32'(tbl[i].e_v2));
      check($sformatf("tbl%0d_q_l2", i),   q2,               tbl[i].e_q2);
    end
    idle();
    tick();

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst_n    = ($urandom_range(149) != 0);
      we       = ($urandom_range(2) != 0);
      be       = 4'($urandom);
      addr_in  = 5'($urandom_range(17));
      d        = $urandom;
      re       = ($urandom_range(2) != 0);
      addr_out = ($urandom_range(3) == 0) ? addr_in : 5'($urandom_range(17));
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
